// File: rtl/mmio_port_controller_pkg.sv
// Shared constants for the MMIO port controller: register word offsets,
// CTRL/STAT bit positions and the CMP reset value.
package mmio_port_controller_pkg;

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_STAT = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_CMP  = 3'd4;
  localparam logic [2:0] OFF_CNT  = 3'd5;

  localparam int CTRL_TEN      = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_IEN_EDGE = 2;
  localparam int CTRL_IEN_TMR  = 3;

  localparam int STAT_TMR = 16;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer.sv
// Compare/match timer: CNT, CMP and TEN with CPU write overrides.
// match pulses when enabled and CNT==CMP (pre-write value).
module mmio_timer
  import mmio_port_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wdata,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic        auto_en,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        ten,
  output logic        match
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        ten_q, ten_d;

  always_comb begin
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    ten_d = ten_q;
    match = ten_q && (cnt_q == cmp_q);
    if (ten_q) begin
      if (match) begin
        if (auto_en) cnt_d = 32'd0;
        else         ten_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    // CPU writes win over the hardware update
    if (cnt_we)  cnt_d = wdata;
    if (cmp_we)  cmp_d = wdata;
    if (ctrl_we) ten_d = wdata[CTRL_TEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
      cmp_q <= CMP_RST;
      ten_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      ten_q <= ten_d;
    end
  end

  assign cnt = cnt_q;
  assign cmp = cmp_q;
  assign ten = ten_q;

endmodule

// File: rtl/mmio_port_controller.sv
// MEM-stage MMIO block: address decode, output port, synchronized input
// with edge flags, W1C status, control and the match timer.
module mmio_port_controller
  import mmio_port_controller_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = 32'hFFFF_0000,
  parameter int          IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                IOSel,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  logic [2:0]          sel;
  logic                wr;
  logic [31:0]         w1c_mask;
  logic [IN_WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [IN_WIDTH-1:0] edge_q, edge_d, rise;
  logic                tmr_q, tmr_d;
  logic [31:0]         out_q, out_d;
  logic                auto_q, auto_d;
  logic                ien_edge_q, ien_edge_d;
  logic                ien_tmr_q, ien_tmr_d;
  logic                irq_q, irq_d;
  logic [31:0]         in_word, stat_word, ctrl_word;
  logic [31:0]         cnt, cmp;
  logic                ten, match;
  logic                unused_addr;

  assign unused_addr = ^Address[1:0];
  assign sel   = Address[4:2];
  assign IOSel = (Address[31:5] == IO_BASE[31:5]) && (sel <= OFF_CNT);
  assign wr    = MemWrite & IOSel;
  assign rise  = s2_q & ~s3_q;

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wdata   (WriteData),
    .cnt_we  (wr && sel == OFF_CNT),
    .cmp_we  (wr && sel == OFF_CMP),
    .ctrl_we (wr && sel == OFF_CTRL),
    .auto_en (auto_q),
    .cnt     (cnt),
    .cmp     (cmp),
    .ten     (ten),
    .match   (match)
  );

  always_comb begin
    in_word   = '0;
    stat_word = '0;
    ctrl_word = '0;
    in_word[IN_WIDTH-1:0]   = s2_q;
    stat_word[IN_WIDTH-1:0] = edge_q;
    stat_word[STAT_TMR]     = stat_word[STAT_TMR] | tmr_q;
    ctrl_word[CTRL_TEN]      = ten;
    ctrl_word[CTRL_AUTO]     = auto_q;
    ctrl_word[CTRL_IEN_EDGE] = ien_edge_q;
    ctrl_word[CTRL_IEN_TMR]  = ien_tmr_q;
  end

  always_comb begin
    out_d      = out_q;
    auto_d     = auto_q;
    ien_edge_d = ien_edge_q;
    ien_tmr_d  = ien_tmr_q;
    w1c_mask   = '0;
    if (wr) begin
      unique case (sel)
        OFF_OUT:  out_d = WriteData;
        OFF_STAT: w1c_mask = WriteData;
        OFF_CTRL: begin
          auto_d     = WriteData[CTRL_AUTO];
          ien_edge_d = WriteData[CTRL_IEN_EDGE];
          ien_tmr_d  = WriteData[CTRL_IEN_TMR];
        end
        default: ;
      endcase
    end
    // new events win over a same-cycle clear
    edge_d = (edge_q & ~w1c_mask[IN_WIDTH-1:0]) | rise;
    tmr_d  = (tmr_q & ~w1c_mask[STAT_TMR]) | match;
    irq_d  = ((|edge_q) & ien_edge_q) | (tmr_q & ien_tmr_q);
  end

  always_comb begin
    ReadData = 32'h0;
    if (IOSel && MemRead) begin
      unique case (sel)
        OFF_OUT:  ReadData = out_q;
        OFF_IN:   ReadData = in_word;
        OFF_STAT: ReadData = stat_word;
        OFF_CTRL: ReadData = ctrl_word;
        OFF_CMP:  ReadData = cmp;
        OFF_CNT:  ReadData = cnt;
        default:  ReadData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      edge_q     <= '0;
      tmr_q      <= 1'b0;
      out_q      <= 32'h0;
      auto_q     <= 1'b0;
      ien_edge_q <= 1'b0;
      ien_tmr_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= PortIn;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      edge_q     <= edge_d;
      tmr_q      <= tmr_d;
      out_q      <= out_d;
      auto_q     <= auto_d;
      ien_edge_q <= ien_edge_d;
      ien_tmr_q  <= ien_tmr_d;
      irq_q      <= irq_d;
    end
  end

  assign PortOut = out_q;
  assign Irq     = irq_q;

endmodule

// File: doc/mmio_port_controller.md
Name: mmio_port_controller

Overview:
Memory-mapped I/O block on the processor's MEM-stage data bus, in parallel with the data RAM. It decodes the EX/MEM ALU address and owns the word registers that drive PortOut. It synchronizes PortIn, latches input rising edges and provides a compare/match timer. Its ReadData and IOSel feed the RAM-vs-I/O read mux ahead of the MEM/WB pipeline register.

Parameters:
IO_BASE, 32'hFFFF_0000, base byte address of the register window; bits [4:0] must be zero.
IN_WIDTH, 8, width of PortIn; 1..32.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Address  input  32  byte address from EX/MEM ALU result
WriteData  input  32  store data from EX/MEM
MemWrite  input  1  store strobe, one cycle per sw
MemRead  input  1  load strobe
PortIn  input  IN_WIDTH  asynchronous external inputs
ReadData  output  32  load data; combinational, valid the same cycle as MemRead
IOSel  output  1  1 when Address hits the register window; combinational
PortOut  output  32  output port register
Irq  output  1  OR of enabled status flags, registered

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Hit: IOSel = (Address[31:5]==IO_BASE[31:5]) and Address[4:2] <= 5. Address[1:0] are ignored; only whole words are accessed.
- A store to RAM must be suppressed when IOSel=1. The top level gates MemWrite; this block does not.
- Register map (offset, name, access):
  - 0x00 OUT: R/W. PortOut = OUT.
  - 0x04 IN: RO. Returns the zero-extended synchronized PortIn.
  - 0x08 STAT: W1C.
    - bits[IN_WIDTH-1:0]: rising-edge flags.
    - bit16: timer match.
  - 0x0C CTRL: R/W.
    - bit0: TEN (timer enable).
    - bit1: AUTO (auto-reload).
    - bit2: IEN_EDGE.
    - bit3: IEN_TMR.
    - Other bits read 0.
  - 0x10 CMP: R/W.
  - 0x14 CNT: R/W.
- Writes take effect when MemWrite & IOSel at the rising edge. Writes to IN are ignored.
- Reads: ReadData = selected register when IOSel & MemRead, else 32'h0. There is no read side effect.
- Input path: two-flop synchronizer s1→s2, then a delay flop s3.
  - IN reads s2.
  - Edge detect = s2 & ~s3.
  - A PortIn change at edge N is visible in IN after edge N+2. The STAT flag sets at edge N+3.
- STAT update order per bit: next = (cur & ~w1c_mask) | set_event.
  - A set and a clear in the same cycle: the set wins.
- Timer, per cycle with TEN=1:
  - If CNT==CMP: set STAT[16]. If AUTO=1, CNT←0. If AUTO=0, CNT holds and TEN←0 (one-shot).
  - Otherwise CNT←CNT+1, wrapping 32'hFFFF_FFFF→0 without setting a flag.
- Timer, with TEN=0: CNT holds.
- Timer priority:
  - A CPU write to CNT overrides the hardware update in the same cycle; the match is still evaluated on the pre-write value.
  - A CPU write to CTRL overrides the one-shot TEN clear.
- Irq: registered, = |(STAT[IN_WIDTH-1:0]) & IEN_EDGE | STAT[16] & IEN_TMR. It has one cycle of latency after STAT.
- Reset values: OUT=0, STAT=0, CTRL=0, CMP=32'hFFFF_FFFF, CNT=0, s1/s2/s3=0. Hence PortOut=0 and Irq=0.
- Reset asserted mid-operation clears all state at the next edge. Any write in that cycle is discarded.
- Pipeline stalls: this block sits after the hazard unit. It sees each MEM-stage access exactly once, and bubbles carry MemRead=MemWrite=0.

Decomposition:
- Shared package: register offset localparams (OFF_OUT … OFF_CNT), CTRL and STAT bit indices, and the reset value of CMP.
- One sub-module: mmio_timer. It holds CNT/CMP/TEN update and match logic, with write-enable inputs and a match pulse output.
- Decode, the synchronizer, STAT and the read mux stay in the top module.

Test Plan:
- Reset, then a store of 32'hA5A5_0F0F to IO_BASE+0 → PortOut=32'hA5A5_0F0F one edge later. A load of IO_BASE+0 returns the same value with IOSel=1. A load of 32'h1001_0000 gives IOSel=0 and ReadData=0.
- PortIn 8'h00→8'h81 at edge N → IN reads 32'h81 after N+2. STAT reads 32'h81 after N+3. Storing 32'h01 to STAT leaves STAT=32'h80.
- With IEN_EDGE set, toggle PortIn[3] 0→1 in the same cycle as a W1C of bit3 → STAT[3] stays 1 and Irq=1.
- CMP=3, CTRL=32'h0B (TEN, AUTO, IEN_TMR) → CNT sequence 1,2,3,0,1… STAT[16] sets on the 3→0 cycle and Irq follows one cycle later.
- CMP=2, CTRL=32'h1 (one-shot) → CNT stops at 2 and CTRL reads 0. A CNT write of 32'hFFFF_FFFF with CMP=5 and TEN=1 wraps to 0 with no flag.
- Assert reset for one edge mid-count with a simultaneous OUT store → all registers return to their reset values and PortOut=0.
